// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient}. Supports divide-by-zero short-cut and annul.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_next;
  logic [2*WIDTH:0]     r_dvd;
  logic [2*WIDTH:0]     w_dvd_next;
  logic [WIDTH-1:0]     r_divisor;
  logic [WIDTH-1:0]     w_divisor_next;
  logic                 r_neg_quot;
  logic                 w_neg_quot_next;
  logic                 r_neg_rem;
  logic                 w_neg_rem_next;
  logic [2*WIDTH-1:0]   r_result;
  logic [2*WIDTH-1:0]   w_result_next;
  logic                 r_ready;
  logic                 w_ready_next;

  logic [WIDTH-1:0]     w_op1_mag;
  logic [WIDTH-1:0]     w_op2_mag;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  assign w_op1_mag  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_op2_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign w_trial    = {1'b0, r_dvd[2*WIDTH-1:WIDTH]} - {1'b0, r_divisor};
  assign w_quot_fix = r_neg_quot ? -r_dvd[WIDTH-1:0] : r_dvd[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_dvd[2*WIDTH:WIDTH+1] : r_dvd[2*WIDTH:WIDTH+1];

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_dvd_next      = r_dvd;
    w_divisor_next  = r_divisor;
    w_neg_quot_next = r_neg_quot;
    w_neg_rem_next  = r_neg_rem;
    w_result_next   = r_result;
    w_ready_next    = r_ready;

    case (r_state)
      S_FREE: begin
        w_result_next = '0;
        w_ready_next  = 1'b0;
        if (start_i && !annul_i) begin
          w_cnt_next = '0;
          if (opdata2_i == '0) begin
            w_state_next = S_BYZERO;
          end else begin
            w_state_next    = S_ON;
            w_dvd_next      = {{WIDTH{1'b0}}, w_op1_mag, 1'b0};
            w_divisor_next  = w_op2_mag;
            // Sign bits are captured here so later operand changes cannot affect the fix-up.
            w_neg_quot_next = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            w_neg_rem_next  = signed_div_i & opdata1_i[WIDTH-1];
          end
        end
      end

      S_BYZERO: begin
        // Two edges in this state so a zero divisor reports ready after start edge + 2.
        if (r_cnt == '0) begin
          w_cnt_next = CW'(1);
        end else begin
          w_state_next  = S_END;
          w_cnt_next    = '0;
          w_result_next = '0;
          w_ready_next  = 1'b1;
        end
      end

      S_ON: begin
        if (annul_i) begin
          w_state_next  = S_FREE;
          w_cnt_next    = '0;
          w_result_next = '0;
          w_ready_next  = 1'b0;
        end else if (r_cnt != CW'(WIDTH)) begin
          if (w_trial[WIDTH]) begin
            w_dvd_next = {r_dvd[2*WIDTH-1:0], 1'b0};
          end else begin
            w_dvd_next = {w_trial[WIDTH-1:0], r_dvd[WIDTH-1:0], 1'b1};
          end
          w_cnt_next = r_cnt + CW'(1);
        end else begin
          w_state_next  = S_END;
          w_cnt_next    = '0;
          w_result_next = {w_rem_fix, w_quot_fix};
          w_ready_next  = 1'b1;
        end
      end

      S_END: begin
        if (!start_i) begin
          w_state_next  = S_FREE;
          w_result_next = '0;
          w_ready_next  = 1'b0;
        end
      end

      default: begin
        w_state_next = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_FREE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_divisor  <= '0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_dvd      <= w_dvd_next;
      r_divisor  <= w_divisor_next;
      r_neg_quot <= w_neg_quot_next;
      r_neg_rem  <= w_neg_rem_next;
      r_result   <= w_result_next;
      r_ready    <= w_ready_next;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule
